// File: rtl/jpeg_pkg.sv
// jpeg_pkg: block geometry and zig-zag to raster mapping for the JPEG decode path.
// Latency: none (constants only).
// Backpressure: not applicable.
package jpeg_pkg;

  localparam int BLK_COEFS = 64;
  localparam int BLK_ROWS  = 8;

  // Zig-zag index -> raster address (row*8 + col).
  localparam logic [5:0] ZZ2RASTER [BLK_COEFS] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/izig_bank.sv
// izig_bank: one 64-entry coefficient bank, random-access write port, 8-wide row read port.
// Latency: write lands on the clock edge; the row read is combinational.
// Backpressure: none; the owner decides when to write and when to release.
// Build option IZIG_EOB_EN: per-entry written mask, unwritten entries read as 0.
module izig_bank
  import jpeg_pkg::*;
#(
  parameter int W = 16
)(
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           i_wr_vld,
  input  logic [5:0]     i_wr_addr,
  input  logic [W-1:0]   i_wr_dat,
  input  logic           i_clr,
  input  logic [2:0]     i_rd_row,
  output logic [8*W-1:0] o_rd_dat
);

  logic [W-1:0] r_mem [BLK_COEFS];

  // Coefficient storage; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (i_wr_vld) r_mem[i_wr_addr] <= i_wr_dat;
  end

`ifdef IZIG_EOB_EN
  logic [BLK_COEFS-1:0] r_mask;

  // Written mask: a bit per stored coefficient, wiped when the bank is released.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      r_mask <= '0;
    else if (i_clr)    r_mask <= '0;
    else if (i_wr_vld) r_mask[i_wr_addr] <= 1'b1;
  end

  // Row read; positions the block never wrote come out as zero.
  always_comb begin
    o_rd_dat = '0;
    for (int c = 0; c < BLK_ROWS; c++) begin
      if (r_mask[{i_rd_row, 3'(c)}]) o_rd_dat[c*W +: W] = r_mem[{i_rd_row, 3'(c)}];
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, rst_n_i, i_clr};

  // Row read straight from storage.
  always_comb begin
    o_rd_dat = '0;
    for (int c = 0; c < BLK_ROWS; c++) begin
      o_rd_dat[c*W +: W] = r_mem[{i_rd_row, 3'(c)}];
    end
  end
`endif

endmodule

// File: rtl/izigzag_deser.sv
// izigzag_deser: zig-zag serial coefficients in, each 8x8 block out as 8 raster rows.
// Latency: row 0 valid two edges after the edge accepting the last beat; rows then stream 1/cycle.
// Backpressure: row_ready_i low holds the row; with both banks full coef_ready_o drops.
// Build option IZIG_EOB_EN: eob_i ends a block early, unwritten coefficients read as 0.
module izigzag_deser
  import jpeg_pkg::*;
#(
  parameter int IZIG_IN_WIDTH  = 16,
  parameter int IZIG_OUT_WIDTH = 16
)(
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [IZIG_IN_WIDTH-1:0]    coef_i,
  input  logic                        coef_valid_i,
  output logic                        coef_ready_o,
  input  logic                        eob_i,
  output logic [8*IZIG_OUT_WIDTH-1:0] row_o,
  output logic                        row_valid_o,
  input  logic                        row_ready_i,
  output logic                        row_sob_o,
  output logic                        row_eob_o
);

  localparam int IW = IZIG_IN_WIDTH;
  localparam int OW = IZIG_OUT_WIDTH;

  logic            r_run;
  logic [5:0]      r_wr_cnt;
  logic            r_wr_bank;
  logic [1:0]      r_full;
  logic [1:0]      r_avail;
  logic            r_ld_bank;
  logic [2:0]      r_ld_row;
  logic            r_out_bank;
  logic [8*OW-1:0] r_row;
  logic            r_row_vld;
  logic            r_row_sob;
  logic            r_row_eob;

  logic            w_acc;
  logic            w_last;
  logic            w_xfer;
  logic            w_rel;
  logic            w_load;
  logic [8*IW-1:0] w_rd0;
  logic [8*IW-1:0] w_rd1;
  logic [8*IW-1:0] w_rd_sel;
  logic [8*OW-1:0] w_row_ext;

  // r_run keeps the input closed while reset is held and opens it one edge later.
  assign coef_ready_o = r_run & ~r_full[r_wr_bank];
  assign w_acc        = coef_valid_i & coef_ready_o;
`ifdef IZIG_EOB_EN
  assign w_last = w_acc & ((r_wr_cnt == 6'd63) | eob_i);
`else
  logic w_unused;
  assign w_unused = eob_i;
  assign w_last   = w_acc & (r_wr_cnt == 6'd63);
`endif

  assign w_xfer = r_row_vld & row_ready_i;
  assign w_rel  = w_xfer & r_row_eob;
  assign w_load = (~r_row_vld | w_xfer) & r_avail[r_ld_bank];

  izig_bank #(.W(IW)) u_bank0 (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .i_wr_vld  (w_acc & ~r_wr_bank),
    .i_wr_addr (ZZ2RASTER[r_wr_cnt]),
    .i_wr_dat  (coef_i),
    .i_clr     (w_rel & ~r_out_bank),
    .i_rd_row  (r_ld_row),
    .o_rd_dat  (w_rd0)
  );

  izig_bank #(.W(IW)) u_bank1 (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .i_wr_vld  (w_acc & r_wr_bank),
    .i_wr_addr (ZZ2RASTER[r_wr_cnt]),
    .i_wr_dat  (coef_i),
    .i_clr     (w_rel & r_out_bank),
    .i_rd_row  (r_ld_row),
    .o_rd_dat  (w_rd1)
  );

  assign w_rd_sel = r_ld_bank ? w_rd1 : w_rd0;

  // Sign-extend each column of the selected row to the output width.
  always_comb begin
    w_row_ext = '0;
    for (int c = 0; c < BLK_ROWS; c++) begin
      w_row_ext[c*OW +: OW] = OW'($signed(w_rd_sel[c*IW +: IW]));
    end
  end

  // Write side: beat counter and fill-bank select.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_run     <= 1'b0;
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_last) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else if (w_acc) begin
        r_wr_cnt <= r_wr_cnt + 6'd1;
      end
    end
  end

  // Bank state: full on completion, empty on last-row transfer; avail lags full by one edge
  // so the first row is read a cycle after the final write settles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_full  <= '0;
      r_avail <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_last && (r_wr_bank == 1'(b)))      r_full[b] <= 1'b1;
        else if (w_rel && (r_out_bank == 1'(b))) r_full[b] <= 1'b0;
        r_avail[b] <= r_full[b] && !(w_rel && (r_out_bank == 1'(b)));
      end
    end
  end

  // Output register: loads the next row whenever it is empty or being taken this cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_row      <= '0;
      r_row_vld  <= 1'b0;
      r_row_sob  <= 1'b0;
      r_row_eob  <= 1'b0;
      r_ld_row   <= '0;
      r_ld_bank  <= 1'b0;
      r_out_bank <= 1'b0;
    end else if (w_load) begin
      r_row      <= w_row_ext;
      r_row_vld  <= 1'b1;
      r_row_sob  <= (r_ld_row == 3'd0);
      r_row_eob  <= (r_ld_row == 3'(BLK_ROWS - 1));
      r_out_bank <= r_ld_bank;
      r_ld_row   <= r_ld_row + 3'd1;
      if (r_ld_row == 3'(BLK_ROWS - 1)) r_ld_bank <= ~r_ld_bank;
    end else if (w_xfer) begin
      r_row_vld <= 1'b0;
      r_row_sob <= 1'b0;
      r_row_eob <= 1'b0;
    end
  end

  assign row_o       = r_row;
  assign row_valid_o = r_row_vld;
  assign row_sob_o   = r_row_sob;
  assign row_eob_o   = r_row_eob;

endmodule

// File: tb/tb_izigzag_deser.sv
// tb_izigzag_deser: scoreboard bench for izigzag_deser.
// Latency: expected rows queued on block completion, compared on each row transfer.
// Backpressure: row_ready_i driven per test (held, released, toggled).
module tb_izigzag_deser;

  localparam int W = 16;
`ifdef IZIG_EOB_EN
  localparam bit EOB_ON = 1'b1;
`else
  localparam bit EOB_ON = 1'b0;
`endif

  typedef struct packed {
    logic         sob;
    logic         eob;
    logic [8*W-1:0] row;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   coef;
  logic           coef_vld;
  logic           coef_rdy;
  logic           eob;
  logic [8*W-1:0] row_dat;
  logic           row_vld;
  logic           row_rdy;
  logic           row_sob;
  logic           row_eob;

  always #5 clk = ~clk;

  izigzag_deser #(.IZIG_IN_WIDTH(W), .IZIG_OUT_WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .coef_i       (coef),
    .coef_valid_i (coef_vld),
    .coef_ready_o (coef_rdy),
    .eob_i        (eob),
    .row_o        (row_dat),
    .row_valid_o  (row_vld),
    .row_ready_i  (row_rdy),
    .row_sob_o    (row_sob),
    .row_eob_o    (row_eob)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rows_out = 0;
  int holds = 0;
  int k = 0;
  int acc_edge = 0;
  int eob_edge = 0;
  bit got_acc = 0;
  bit rdy_low_seen = 0;
  bit stall_prev = 0;
  bit toggle_rdy = 0;
  logic [8*W-1:0] prev_row;
  logic prev_sob, prev_eob;
  logic [W-1:0] blk [64];
  int zz [64];
  exp_t sb [$];
  exp_t cap [$];
  logic [8*W-1:0] e_row0, e_row1;

  task automatic chk(input string tag, input logic [8*W-1:0] got, input logic [8*W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a completed block becomes 8 expected raster rows.
  task automatic push_block();
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      e.sob = (r == 0);
      e.eob = (r == 7);
      e.row = '0;
      for (int c = 0; c < 8; c++) e.row[c*W +: W] = blk[r*8 + c];
      sb.push_back(e);
    end
    blk = '{default: '0};
  endtask

  task automatic model_reset();
    k = 0;
    blk = '{default: '0};
    sb.delete();
    stall_prev = 0;
  endtask

  // Observe one cycle at the negedge: what will be accepted / transferred at the next edge.
  task automatic mon();
    exp_t e;
    if (coef_vld && !coef_rdy) rdy_low_seen = 1;
    if (coef_vld && coef_rdy) begin
      got_acc  = 1;
      acc_edge = cyc + 1;
      blk[zz[k]] = coef;
      if (k == 63 || (EOB_ON && eob)) begin
        push_block();
        k = 0;
      end else begin
        k++;
      end
    end
    if (stall_prev) begin
      holds++;
      chk("hold_vld", row_vld, 1);
      chk("hold_row", row_dat, prev_row);
      chk("hold_flags", {row_sob, row_eob}, {prev_sob, prev_eob});
    end
    stall_prev = row_vld && !row_rdy;
    prev_row = row_dat;
    prev_sob = row_sob;
    prev_eob = row_eob;
    if (row_vld && row_rdy) begin
      rows_out++;
      e.sob = row_sob; e.eob = row_eob; e.row = row_dat;
      cap.push_back(e);
      if (row_eob) eob_edge = cyc + 1;
      if (sb.size() == 0) begin
        chk("row_extra", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("row_dat", row_dat, e.row);
        chk("row_sob", row_sob, e.sob);
        chk("row_eob", row_eob, e.eob);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
    if (toggle_rdy) row_rdy = ~row_rdy;
  endtask

  task automatic push_beat(input logic [W-1:0] v, input logic e);
    int n = 0;
    coef = v; eob = e; coef_vld = 1; got_acc = 0;
    while (!got_acc && n < 300) begin tick(); n++; end
    if (!got_acc) chk("beat_timeout", 0, 1);
    coef_vld = 0; eob = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || row_vld) && n < 300) begin tick(); n++; end
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    int kk, base, n;
    rst_n = 0; coef = '0; coef_vld = 0; eob = 0; row_rdy = 0;
    // Bench's own zig-zag walk along anti-diagonals.
    kk = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 1) begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin zz[kk] = r*8 + (s - r); kk++; end
      end else begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin zz[kk] = r*8 + (s - r); kk++; end
      end
    end
    model_reset();

    // Reset state
    #3;
    chk("rst_row", row_dat, 0);
    chk("rst_vld", row_vld, 0);
    chk("rst_sob", row_sob, 0);
    chk("rst_eob", row_eob, 0);
    chk("rst_rdy", coef_rdy, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_rdy_after", coef_rdy, 1);

    // Test 1: ramp, latency and literal rows
    row_rdy = 1; cap.delete(); base = rows_out;
    for (int i = 0; i < 64; i++) push_beat(W'(i), 0);
    chk("t1_lat0", row_vld, 0);
    tick();
    chk("t1_lat1", row_vld, 0);
    tick();
    chk("t1_lat2", row_vld, 1);
    drain();
    chk("t1_rows", rows_out - base, 8);
    e_row0 = {16'd28, 16'd27, 16'd15, 16'd14, 16'd6, 16'd5, 16'd1, 16'd0};
    e_row1 = {16'd42, 16'd29, 16'd26, 16'd16, 16'd13, 16'd7, 16'd4, 16'd2};
    if (cap.size() >= 2) begin
      chk("t1_row0", cap[0].row, e_row0);
      chk("t1_row1", cap[1].row, e_row1);
    end else chk("t1_cap", cap.size(), 2);

    // Test 2: two blocks back-to-back, input never stalls
    rdy_low_seen = 0; base = rows_out;
    for (int i = 0; i < 128; i++) push_beat(W'($urandom()), 0);
    chk("t2_no_stall", rdy_low_seen, 0);
    drain();
    chk("t2_rows", rows_out - base, 16);

    // Test 3: sink blocked, both banks fill, input resumes after block A's row 7
    row_rdy = 0; base = rows_out;
    for (int i = 0; i < 128; i++) push_beat(W'(i * 3 + 7), 0);
    rdy_low_seen = 0;
    coef = 16'h0129; coef_vld = 1; got_acc = 0;
    repeat (4) tick();
    chk("t3_stall", coef_rdy, 0);
    chk("t3_low_seen", rdy_low_seen, 1);
    chk("t3_not_acc", got_acc, 0);
    row_rdy = 1; n = 0;
    while (!got_acc && n < 100) begin tick(); n++; end
    if (!got_acc) chk("t3_timeout", 0, 1);
    chk("t3_resume", acc_edge, eob_edge + 1);
    coef_vld = 0;
    push_beat(16'h0130, 0);
    drain();
    chk("t3_rows", rows_out - base, 16);

    // Test 4: sink ready toggling; finish the partial block plus one more
    toggle_rdy = 1; row_rdy = 1; base = rows_out; holds = 0;
    for (int i = 0; i < 126; i++) push_beat(W'(16'h8000 + i * 5), 0);
    drain();
    toggle_rdy = 0; row_rdy = 1;
    chk("t4_rows", rows_out - base, 16);
    chk("t4_held", holds > 0, 1);

    // Test 5: reset mid-block, partial discarded
    for (int i = 0; i < 30; i++) push_beat(W'(16'h4000 + i), 0);
    rst_n = 0;
    #2;
    chk("t5_row", row_dat, 0);
    chk("t5_vld", row_vld, 0);
    chk("t5_flags", {row_sob, row_eob}, 0);
    chk("t5_rdy", coef_rdy, 0);
    model_reset();
    tick();
    #2 rst_n = 1;
    tick();
    chk("t5_rdy_after", coef_rdy, 1);
    base = rows_out;
    for (int i = 0; i < 64; i++) push_beat(W'(1000 + i), 0);
    drain();
    chk("t5_rows", rows_out - base, 8);

`ifdef IZIG_EOB_EN
    // Test 6: short block closed by eob_i
    cap.delete(); base = rows_out;
    push_beat(16'd5, 0);
    push_beat(16'hFFFE, 0);
    push_beat(16'd7, 1);
    drain();
    chk("t6_rows", rows_out - base, 8);
    e_row0 = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFE, 16'd5};
    e_row1 = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7};
    if (cap.size() >= 2) begin
      chk("t6_row0", cap[0].row, e_row0);
      chk("t6_row1", cap[1].row, e_row1);
    end else chk("t6_cap", cap.size(), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
